// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN,
        MD_BUSY
    } hc_state_t;

    localparam logic [4:0]  REG_ZERO          = 5'd0;
    localparam int unsigned MD_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit occupancy timer: busy for MD_CYCLES cycles after start, done on the last one.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    hc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        busy    = (state_q == MD_BUSY) && !rst;
        done    = busy && (cnt_q == '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MD_BUSY) begin
            if (cnt_q == '0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        // A start in the final busy cycle reloads, so back-to-back ops have no idle gap.
        if (start) begin
            state_d = MD_BUSY;
            cnt_d   = CNT_W'(MD_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch and mult/div hazards.
// Optional perf counters (stall_cycles, flush_events) built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rs_id,
    input  logic       uses_rt_id,
    input  logic       md_start_id,
    input  logic       md_read_id,
    input  logic       mem_rd_id_ex,
    input  logic       wr_en_reg_id_ex,
    input  logic [4:0] wr_num_id_ex,
    input  logic       branch_taken_ex,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    logic lu_hazard;
    logic mh_hazard;
    logic md_issue;

    always_comb begin
        lu_hazard = mem_rd_id_ex && wr_en_reg_id_ex && (wr_num_id_ex != REG_ZERO) &&
                    ((uses_rs_id && (rs_id == wr_num_id_ex)) ||
                     (uses_rt_id && (rt_id == wr_num_id_ex)));
        // The final busy cycle forwards HI/LO, so only earlier cycles stall.
        mh_hazard = md_busy && (md_start_id || md_read_id) && !md_done;

        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_hazard || mh_hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end

        md_issue = md_start_id && !rst && !branch_taken_ex && !lu_hazard && !mh_hazard;
    end

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_busy_timer (
        .clk   (clk),
        .rst   (rst),
        .start (md_issue),
        .busy  (md_busy),
        .done  (md_done)
    );

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (pc_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (branch_taken_ex && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with MD_CYCLES=4; perf test under HAZARD_CTRL_PERF_EN.
module tb_hazard_ctrl;

    localparam int unsigned MD = 4;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done}
    localparam logic [5:0] NONE   = 6'b000000;
    localparam logic [5:0] STALL  = 6'b110100;
    localparam logic [5:0] FLUSH  = 6'b001100;
    localparam logic [5:0] BUSY   = 6'b000010;
    localparam logic [5:0] BSTALL = 6'b110110;
    localparam logic [5:0] BFLUSH = 6'b001110;
    localparam logic [5:0] DONE   = 6'b000011;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       mds;
        logic       mdr;
        logic       memrd;
        logic       wren;
        logic       urs;
        logic       urt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_id, rt_id, wr_num_id_ex;
    logic       uses_rs_id, uses_rt_id, md_start_id, md_read_id;
    logic       mem_rd_id_ex, wr_en_reg_id_ex, branch_taken_ex;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    logic [5:0] obs;
    assign obs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy, md_done};

    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MD_CYCLES (MD),
        .CNT_W     (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .uses_rs_id      (uses_rs_id),
        .uses_rt_id      (uses_rt_id),
        .md_start_id     (md_start_id),
        .md_read_id      (md_read_id),
        .mem_rd_id_ex    (mem_rd_id_ex),
        .wr_en_reg_id_ex (wr_en_reg_id_ex),
        .wr_num_id_ex    (wr_num_id_ex),
        .branch_taken_ex (branch_taken_ex),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .md_busy         (md_busy),
        .md_done         (md_done)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rs = 5'd3;
        s.rt = 5'd4;
        s.wr = 5'd9;
        return s;
    endfunction

    function automatic stim_t lu_s();
        stim_t s;
        s = idle_s();
        s.memrd = 1'b1;
        s.wren  = 1'b1;
        s.wr    = 5'd8;
        s.rs    = 5'd8;
        s.urs   = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst             = s.rst;
        branch_taken_ex = s.br;
        md_start_id     = s.mds;
        md_read_id      = s.mdr;
        mem_rd_id_ex    = s.memrd;
        wr_en_reg_id_ex = s.wren;
        uses_rs_id      = s.urs;
        uses_rt_id      = s.urt;
        rs_id           = s.rs;
        rt_id           = s.rt;
        wr_num_id_ex    = s.wr;
    endtask

    task automatic test_reset();
        stim_t s[3];
        logic [5:0] x[3];
        logic [5:0] e;
        s[0] = idle_s(); s[0].rst = 1'b1; x[0] = FLUSH;
        s[1] = lu_s();   s[1].rst = 1'b1; x[1] = FLUSH;
        s[2] = idle_s();                  x[2] = NONE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[8];
        logic [5:0] x[8];
        logic [5:0] e;
        s[0] = lu_s();                            x[0] = STALL;
        s[1] = idle_s();                          x[1] = NONE;
        s[2] = lu_s(); s[2].wr = 5'd0; s[2].rs = 5'd0; x[2] = NONE;
        s[3] = lu_s(); s[3].urs = 1'b0;           x[3] = NONE;
        s[4] = lu_s(); s[4].rs = 5'd1; s[4].urt = 1'b1; s[4].rt = 5'd8; x[4] = STALL;
        s[5] = lu_s(); s[5].memrd = 1'b0;         x[5] = NONE;
        s[6] = lu_s(); s[6].wren = 1'b0;          x[6] = NONE;
        s[7] = lu_s(); s[7].rs = 5'd7;            x[7] = NONE;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[6];
        logic [5:0] x[6];
        logic [5:0] e;
        s[0] = lu_s();   s[0].br = 1'b1;  x[0] = FLUSH;
        s[1] = idle_s(); s[1].br = 1'b1;  x[1] = FLUSH;
        s[2] = idle_s(); s[2].br = 1'b1; s[2].mds = 1'b1; x[2] = FLUSH;
        s[3] = idle_s();                  x[3] = NONE;   // killed start never issued
        s[4] = lu_s();   s[4].mds = 1'b1; x[4] = STALL;
        s[5] = idle_s();                  x[5] = NONE;   // stalled start never issued
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_md_window();
        stim_t s[12];
        logic [5:0] x[12];
        logic [5:0] e;
        s[0] = idle_s(); s[0].mds = 1'b1; x[0] = NONE;
        for (int i = 1; i <= 3; i++) begin
            s[i] = idle_s(); s[i].mdr = 1'b1; x[i] = BSTALL;
        end
        s[4] = idle_s(); s[4].mdr = 1'b1; x[4] = DONE;
        s[5] = idle_s(); s[5].mdr = 1'b1; x[5] = NONE;
        // Branch during busy must not cancel the counter.
        s[6]  = idle_s(); s[6].mds = 1'b1; x[6]  = NONE;
        s[7]  = idle_s(); s[7].br = 1'b1;  x[7]  = BFLUSH;
        s[8]  = idle_s();                  x[8]  = BUSY;
        s[9]  = idle_s();                  x[9]  = BUSY;
        s[10] = idle_s();                  x[10] = DONE;
        s[11] = idle_s();                  x[11] = NONE;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL md_window[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[10];
        logic [5:0] x[10];
        logic [5:0] e;
        s[0] = idle_s(); s[0].mds = 1'b1; x[0] = NONE;
        for (int i = 1; i <= 3; i++) begin
            s[i] = idle_s(); s[i].mds = 1'b1; x[i] = BSTALL;
        end
        s[4] = idle_s(); s[4].mds = 1'b1; x[4] = DONE;
        for (int i = 5; i <= 7; i++) begin
            s[i] = idle_s(); x[i] = BUSY;
        end
        s[8] = idle_s(); x[8] = DONE;
        s[9] = idle_s(); x[9] = NONE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t s[7];
        logic [5:0] x[7];
        logic [5:0] e;
        s[0] = idle_s(); s[0].mds = 1'b1; x[0] = NONE;
        s[1] = idle_s();                  x[1] = BUSY;   // cnt=3
        s[2] = idle_s(); s[2].rst = 1'b1; s[2].mdr = 1'b1; x[2] = FLUSH;  // cnt=2
        s[3] = idle_s();                  x[3] = NONE;
        s[4] = idle_s(); s[4].mdr = 1'b1; x[4] = NONE;
        s[5] = idle_s();                  x[5] = NONE;
        s[6] = idle_s();                  x[6] = NONE;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_op[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

`ifdef HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        stim_t s[10];
        logic [5:0] x[10];
        logic [5:0] e;
        s[0] = idle_s(); s[0].rst = 1'b1; s[0].br = 1'b1; x[0] = FLUSH;
        s[1] = lu_s();                    x[1] = STALL;
        s[2] = idle_s();                  x[2] = NONE;
        s[3] = lu_s();                    x[3] = STALL;
        s[4] = lu_s(); s[4].br = 1'b1;    x[4] = FLUSH;
        s[5] = idle_s();                  x[5] = NONE;
        s[6] = lu_s();                    x[6] = STALL;
        s[7] = idle_s(); s[7].br = 1'b1;  x[7] = FLUSH;
        s[8] = idle_s();                  x[8] = NONE;
        s[9] = idle_s();                  x[9] = NONE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(s[i]);
            exp_q.push_back(x[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL perf_out[%0d]: got %b expected %b", i, obs, e);
            end
        end
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 3", stall_cycles);
        end
        checks++;
        if (flush_events !== 32'd2) begin
            errors++;
            $display("FAIL flush_events: got %0d expected 2", flush_events);
        end
    endtask
`endif

    initial begin
        stim_t s0;
        s0 = idle_s();
        s0.rst = 1'b1;
        apply(s0);
        test_reset();
        test_load_use();
        test_branch();
        test_md_window();
        test_back_to_back();
        test_reset_mid_op();
`ifdef HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
